minterm_scanner: RTL

Sequential truth-table reader for the team's generated sum-of-minterms logic. It drives every input combination of an N-variable combinational function-under-test in ascending order and samples the function's output. Each index where the output is 1 is streamed out on a valid/ready port, so the minterm list can be recovered from hardware and checked against the list the function was generated from. It sits beside a generated minterm module: `probe` feeds that module's inputs and its `out` returns on `func_in`.

---
 rtl/minterm_scanner.sv | 90 +++++++++
 1 files changed

// File: rtl/minterm_scanner.sv
// Sequential truth-table reader: steps probe through all 2^N_VARS indices and
// streams every index where func_in is 1 out on a valid/ready port.
module minterm_scanner #(
  parameter int N_VARS = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N_VARS-1:0] probe,
  input  logic              func_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic              busy,
  output logic              done,
  output logic [N_VARS:0]   count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    FINISH
  } state_t;

  localparam logic [N_VARS-1:0] MAX_INDEX = '1;

  state_t state;
  logic   at_max;

  assign at_max = (probe == MAX_INDEX);

  // busy/done are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      probe   <= '0;
      m_valid <= 1'b0;
      m_index <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            probe <= '0;
            count <= '0;
          end
        end
        SCAN: begin
          if (func_in) begin
            m_index <= probe;
            m_valid <= 1'b1;
            count   <= count + 1'b1;
            state   <= EMIT;
          end else if (at_max) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            probe <= probe + 1'b1;
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (at_max) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              probe <= probe + 1'b1;
              state <= SCAN;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
